// File: rtl/mem_access_stage.sv
// MEM stage of the 16-bit pipeline: direct-mapped, write-through, no-write-allocate data
// cache with a req/ack backing-memory port, the MEM_WB register and branch select.
module mem_access_stage #(
    parameter int INDEX_BITS = 4
) (
    input  logic        inp_clk,
    input  logic        inp_rst,
    input  logic        inp_zero,
    input  logic [15:0] inp_aluResult,
    input  logic [15:0] inp_data2,
    input  logic [2:0]  inp_selectReg,
    input  logic [15:0] inp_branchAddress,
    input  logic        inp_memToReg,
    input  logic        inp_regWrite,
    input  logic        inp_memRead,
    input  logic        inp_memWrite,
    input  logic        inp_branch,
    input  logic [15:0] inp_memRdata,
    input  logic        inp_memAck,
    output logic        out_hit,
    output logic        out_pcSrc,
    output logic [15:0] out_branchAddress,
    output logic        out_memReq,
    output logic        out_memWe,
    output logic [15:0] out_memAddr,
    output logic [15:0] out_memWdata,
    output logic [15:0] out_wbData,
    output logic [2:0]  out_wbSelectReg,
    output logic        out_wbRegWrite
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 16 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RFILL = 2'd1,
        WRITE = 2'd2,
        WDONE = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [LINES-1:0]        valid_r;
    logic [TAG_W-1:0]        tag_r  [LINES];
    logic [15:0]             line_r [LINES];
    logic [INDEX_BITS-1:0]   idx_s;
    logic [TAG_W-1:0]        tag_s;
    logic                    rhit_s;
    logic                    is_store_s;
    logic                    is_load_s;
    logic                    hit_s;
    logic                    fill_s;
    logic                    wupd_s;
    logic                    req_next_s;
    logic                    mem_req_r;
    logic                    mem_we_r;
    logic [15:0]             mem_addr_r;
    logic [15:0]             mem_wdata_r;
    logic [15:0]             wb_data_r;
    logic [2:0]              wb_sel_r;
    logic                    wb_we_r;

    assign idx_s      = inp_aluResult[INDEX_BITS-1:0];
    assign tag_s      = inp_aluResult[15:INDEX_BITS];
    assign rhit_s     = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    // A store wins when both read and write controls are raised.
    assign is_store_s = inp_memWrite;
    assign is_load_s  = inp_memRead & ~inp_memWrite;
    assign req_next_s = (state_next_s == RFILL) || (state_next_s == WRITE);

    // Next-state, advance enable and cache-update strobes.
    always_comb begin
        state_next_s = state_r;
        hit_s        = 1'b0;
        fill_s       = 1'b0;
        wupd_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (is_store_s) begin
                    state_next_s = WRITE;
                end else if (is_load_s) begin
                    if (rhit_s) begin
                        hit_s = 1'b1;
                    end else begin
                        state_next_s = RFILL;
                    end
                end else begin
                    hit_s = 1'b1;
                end
            end
            RFILL: begin
                if (inp_memAck) begin
                    fill_s       = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RFILL;
                end
            end
            WRITE: begin
                if (inp_memAck) begin
                    wupd_s       = rhit_s;
                    state_next_s = WDONE;
                end else begin
                    state_next_s = WRITE;
                end
            end
            WDONE: begin
                hit_s        = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(negedge inp_clk or posedge inp_rst) begin
        if (inp_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Backing-memory request; drops on the edge that samples the ack.
    always_ff @(negedge inp_clk or posedge inp_rst) begin
        if (inp_rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 16'h0000;
            mem_wdata_r <= 16'h0000;
        end else begin
            mem_req_r <= req_next_s;
            mem_we_r  <= (state_next_s == WRITE);
            if (req_next_s) begin
                mem_addr_r  <= inp_aluResult;
                mem_wdata_r <= inp_data2;
            end else begin
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // Line valid bits; the only cache state that needs a reset.
    always_ff @(negedge inp_clk or posedge inp_rst) begin
        if (inp_rst) begin
            valid_r <= '0;
        end else if (fill_s) begin
            valid_r[idx_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data arrays: fill overwrites (evicts), store hit updates the word in place.
    always_ff @(negedge inp_clk) begin
        if (fill_s) begin
            tag_r[idx_s]  <= tag_s;
            line_r[idx_s] <= inp_memRdata;
        end else if (wupd_s) begin
            line_r[idx_s] <= inp_data2;
        end
    end

    // MEM_WB register; a stalled edge inserts a bubble so WB never writes twice.
    always_ff @(negedge inp_clk or posedge inp_rst) begin
        if (inp_rst) begin
            wb_data_r <= 16'h0000;
            wb_sel_r  <= 3'd0;
            wb_we_r   <= 1'b0;
        end else if (hit_s) begin
            wb_data_r <= inp_memToReg ? line_r[idx_s] : inp_aluResult;
            wb_sel_r  <= inp_selectReg;
            wb_we_r   <= inp_regWrite;
        end else begin
            wb_we_r   <= 1'b0;
        end
    end

    assign out_hit           = hit_s;
    assign out_pcSrc         = inp_branch & inp_zero;
    assign out_branchAddress = inp_branchAddress;
    assign out_memReq        = mem_req_r;
    assign out_memWe         = mem_we_r;
    assign out_memAddr       = mem_addr_r;
    assign out_memWdata      = mem_wdata_r;
    assign out_wbData        = wb_data_r;
    assign out_wbSelectReg   = wb_sel_r;
    assign out_wbRegWrite    = wb_we_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a memory/cache reference model predicts write-backs,
// memory requests and stall lengths; a monitor compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_mem_access_stage;
    logic        inp_clk = 1'b0;
    logic        inp_rst = 1'b1;
    logic        inp_zero = 1'b0;
    logic [15:0] inp_aluResult = 16'h0000;
    logic [15:0] inp_data2 = 16'h0000;
    logic [2:0]  inp_selectReg = 3'd0;
    logic [15:0] inp_branchAddress = 16'h0000;
    logic        inp_memToReg = 1'b0;
    logic        inp_regWrite = 1'b0;
    logic        inp_memRead = 1'b0;
    logic        inp_memWrite = 1'b0;
    logic        inp_branch = 1'b0;
    logic [15:0] inp_memRdata = 16'h0000;
    logic        inp_memAck = 1'b0;
    logic        out_hit;
    logic        out_pcSrc;
    logic [15:0] out_branchAddress;
    logic        out_memReq;
    logic        out_memWe;
    logic [15:0] out_memAddr;
    logic [15:0] out_memWdata;
    logic [15:0] out_wbData;
    logic [2:0]  out_wbSelectReg;
    logic        out_wbRegWrite;

    mem_access_stage #(.INDEX_BITS(4)) dut (
        .inp_clk(inp_clk), .inp_rst(inp_rst), .inp_zero(inp_zero),
        .inp_aluResult(inp_aluResult), .inp_data2(inp_data2), .inp_selectReg(inp_selectReg),
        .inp_branchAddress(inp_branchAddress), .inp_memToReg(inp_memToReg),
        .inp_regWrite(inp_regWrite), .inp_memRead(inp_memRead), .inp_memWrite(inp_memWrite),
        .inp_branch(inp_branch), .inp_memRdata(inp_memRdata), .inp_memAck(inp_memAck),
        .out_hit(out_hit), .out_pcSrc(out_pcSrc), .out_branchAddress(out_branchAddress),
        .out_memReq(out_memReq), .out_memWe(out_memWe), .out_memAddr(out_memAddr),
        .out_memWdata(out_memWdata), .out_wbData(out_wbData),
        .out_wbSelectReg(out_wbSelectReg), .out_wbRegWrite(out_wbRegWrite)
    );

    always #5 inp_clk = ~inp_clk;

    typedef struct packed { logic [15:0] data; logic [2:0] sel; } wb_t;
    typedef struct packed { logic we; logic [15:0] addr; logic [15:0] wdata; } req_t;

    wb_t         wb_q[$];
    req_t        req_q[$];
    int          stall_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    bit          mon_en = 1'b0;
    bit          resp_en = 1'b0;
    int          force_delay = 0;
    int          run_len = 0;
    logic        prev_hit = 1'b1;
    logic        prev_req = 1'b0;
    logic [15:0] bmem    [64];
    logic [15:0] ref_mem [64];
    bit          ref_valid [16];
    logic [11:0] ref_tag   [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Backing memory: random ack delay (edges from request to acking edge), stall = delay + 1.
    initial begin
        forever begin
            @(posedge inp_clk);
            if (resp_en && out_memReq === 1'b1) begin
                int d;
                d = (force_delay != 0) ? force_delay : int'($urandom_range(1, 4));
                force_delay = 0;
                stall_q.push_back(d + 1);
                repeat (d - 1) @(negedge inp_clk);
                #1;
                if (out_memWe === 1'b1) bmem[out_memAddr[5:0]] = out_memWdata;
                else inp_memRdata = bmem[out_memAddr[5:0]];
                inp_memAck = 1'b1;
                @(negedge inp_clk);
                #1;
                inp_memAck = 1'b0;
                inp_memRdata = 16'($urandom);
            end
        end
    end

    // Monitor: samples on posedge, away from the negedge where the DUT updates.
    initial begin
        forever begin
            @(posedge inp_clk);
            if (mon_en) begin
                wb_t  w;
                req_t r;
                int   s;
                check("pcSrc", 32'(out_pcSrc), 32'(inp_branch & inp_zero));
                check("branchAddress", 32'(out_branchAddress), 32'(inp_branchAddress));
                if (prev_hit !== 1'b1) begin
                    check("wb_bubble_in_stall", 32'(out_wbRegWrite), 32'd0);
                end else if (out_wbRegWrite === 1'b1) begin
                    if (wb_q.size() == 0) begin
                        check("wb_unexpected", 32'd1, 32'd0);
                    end else begin
                        w = wb_q.pop_front();
                        check("wbData", 32'(out_wbData), 32'(w.data));
                        check("wbSelectReg", 32'(out_wbSelectReg), 32'(w.sel));
                    end
                end
                if (out_memReq === 1'b1 && prev_req !== 1'b1) begin
                    if (req_q.size() == 0) begin
                        check("memReq_unexpected", 32'd1, 32'd0);
                    end else begin
                        r = req_q.pop_front();
                        check("memWe", 32'(out_memWe), 32'(r.we));
                        check("memAddr", 32'(out_memAddr), 32'(r.addr));
                        check("memWdata", 32'(out_memWdata), 32'(r.wdata));
                    end
                end
                if (out_hit !== 1'b1) begin
                    run_len++;
                end else if (run_len > 0) begin
                    s = (stall_q.size() == 0) ? 0 : stall_q.pop_front();
                    check("stall_cycles", 32'(run_len), 32'(s));
                    run_len = 0;
                end
            end
            prev_hit = out_hit;
            prev_req = out_memReq;
        end
    end

    // kind: 0 ALU, 1 load, 2 store, 3 read+write (behaves as store). Returns posedges to advance.
    task automatic issue(input int kind, input logic [15:0] addr, input logic [15:0] d2,
                         input logic [2:0] sel, input logic rw, output int cyc);
        logic [3:0]  idx;
        logic [11:0] tg;
        bit          hit;
        @(negedge inp_clk);
        #1;
        inp_aluResult     = addr;
        inp_data2         = d2;
        inp_selectReg     = sel;
        inp_memRead       = (kind == 1) || (kind == 3);
        inp_memWrite      = (kind >= 2);
        inp_memToReg      = (kind == 1);
        inp_regWrite      = (kind <= 1) ? rw : 1'b0;
        inp_branch        = 1'($urandom);
        inp_zero          = 1'($urandom);
        inp_branchAddress = 16'($urandom);
        idx = addr[3:0];
        tg  = addr[15:4];
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        if (kind == 0) begin
            if (rw) wb_q.push_back('{data: addr, sel: sel});
        end else if (kind == 1) begin
            if (!hit) begin
                req_q.push_back('{we: 1'b0, addr: addr, wdata: d2});
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tg;
            end
            if (rw) wb_q.push_back('{data: ref_mem[addr[5:0]], sel: sel});
        end else begin
            req_q.push_back('{we: 1'b1, addr: addr, wdata: d2});
            ref_mem[addr[5:0]] = d2;
        end
        cyc = 0;
        do begin
            @(posedge inp_clk);
            cyc++;
        end while (out_hit !== 1'b1 && cyc < 40);
        if (out_hit !== 1'b1) check("op_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 64; i++) begin
            bmem[i]    = 16'($urandom);
            ref_mem[i] = bmem[i];
        end
        bmem[6'h13] = 16'hBEEF;
        ref_mem[6'h13] = 16'hBEEF;

        repeat (3) @(posedge inp_clk);
        check("rst_memReq", 32'(out_memReq), 32'd0);
        check("rst_memWe", 32'(out_memWe), 32'd0);
        check("rst_memAddr", 32'(out_memAddr), 32'd0);
        check("rst_memWdata", 32'(out_memWdata), 32'd0);
        check("rst_wbData", 32'(out_wbData), 32'd0);
        check("rst_wbSelectReg", 32'(out_wbSelectReg), 32'd0);
        check("rst_wbRegWrite", 32'(out_wbRegWrite), 32'd0);
        check("rst_hit_noop", 32'(out_hit), 32'd1);

        // Reset in the middle of a refill, then a stray ack aimed at the same line.
        @(negedge inp_clk);
        #1;
        inp_rst = 1'b0;
        inp_aluResult = 16'h0013;
        inp_memRead = 1'b1;
        inp_memToReg = 1'b1;
        inp_regWrite = 1'b1;
        repeat (3) @(posedge inp_clk);
        check("req_before_reset", 32'(out_memReq), 32'd1);
        check("stall_before_reset", 32'(out_hit), 32'd0);
        #1 inp_rst = 1'b1;
        #1 check("rst_drops_req", 32'(out_memReq), 32'd0);
        inp_memRead = 1'b0;
        inp_memToReg = 1'b0;
        inp_regWrite = 1'b0;
        #1 check("rst_idle_hit", 32'(out_hit), 32'd1);
        #1 inp_rst = 1'b0;
        @(negedge inp_clk);
        #1;
        inp_memAck = 1'b1;
        inp_memRdata = 16'h5555;
        @(negedge inp_clk);
        #1;
        inp_memAck = 1'b0;
        repeat (2) begin
            @(posedge inp_clk);
            check("stray_ack_no_req", 32'(out_memReq), 32'd0);
            check("stray_ack_hit", 32'(out_hit), 32'd1);
        end
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        run_len = 0;
        mon_en  = 1'b1;
        resp_en = 1'b1;

        force_delay = 3;
        issue(1, 16'h0013, 16'h0000, 3'd1, 1'b1, cyc);
        check("cold_miss_stall", 32'(cyc - 1), 32'd4);
        issue(1, 16'h0013, 16'h0000, 3'd2, 1'b1, cyc);
        check("repeat_load_hit", 32'(cyc - 1), 32'd0);
        issue(2, 16'h0013, 16'h1234, 3'd0, 1'b0, cyc);
        issue(1, 16'h0013, 16'h0000, 3'd3, 1'b1, cyc);
        check("load_after_store_hit", 32'(cyc - 1), 32'd0);
        issue(2, 16'h0025, 16'hA5A5, 3'd0, 1'b0, cyc);
        issue(1, 16'h0025, 16'h0000, 3'd4, 1'b1, cyc);
        issue(1, 16'h0003, 16'h0000, 3'd6, 1'b1, cyc);
        issue(1, 16'h0013, 16'h0000, 3'd7, 1'b1, cyc);
        issue(1, 16'h0003, 16'h0000, 3'd1, 1'b1, cyc);
        issue(0, 16'h00FF, 16'h0000, 3'd5, 1'b1, cyc);

        for (int n = 0; n < 250; n++) begin
            int k;
            int kind;
            k = int'($urandom_range(0, 9));
            kind = (k <= 2) ? 0 : (k <= 6) ? 1 : (k <= 8) ? 2 : 3;
            issue(kind, (kind == 0) ? 16'($urandom) : 16'($urandom_range(0, 63)),
                  16'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0), cyc);
        end
        issue(0, 16'h0000, 16'h0000, 3'd0, 1'b0, cyc);
        repeat (3) @(posedge inp_clk);
        check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        check("req_queue_drained", 32'(req_q.size()), 32'd0);
        check("stall_queue_drained", 32'(stall_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
